// File: rtl/fejkon_pcie_pkg.sv
// Shared types for the fejkon PCIe completion generator.
// Completion header layout, status codes and FSM states.
package fejkon_pcie_pkg;

    localparam logic [2:0] FMT_CPLD = 3'b010;
    localparam logic [2:0] FMT_CPL  = 3'b000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    typedef enum logic [2:0] {
        CPL_SC = 3'b000,
        CPL_UR = 3'b001,
        CPL_CA = 3'b100
    } cpl_status_e;

    typedef enum logic [1:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        TX
    } cpl_state_e;

    // DW0 occupies the low 32 bits so the struct drops straight into the beat.
    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic        rsvd2;
        logic [6:0]  lower_addr;
        logic [15:0] cpl_id;
        cpl_status_e status;
        logic        bcm;
        logic [11:0] byte_count;
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic        t9;
        logic [2:0]  tc;
        logic [3:0]  rsvd0;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [1:0]  at;
        logic [9:0]  length;
    } cpl_hdr_t;

    function automatic cpl_hdr_t cpl_hdr(
        input logic [2:0]  fmt,
        input cpl_status_e status,
        input logic [9:0]  length,
        input logic [15:0] cpl_id,
        input logic [15:0] req_id,
        input logic [7:0]  tag,
        input logic [2:0]  tc,
        input logic [1:0]  attr,
        input logic [11:0] byte_count,
        input logic [6:0]  lower_addr
    );
        cpl_hdr_t h;
        h            = '0;
        h.fmt        = fmt;
        h.typ        = TYPE_CPL;
        h.tc         = tc;
        h.attr       = attr;
        h.length     = length;
        h.cpl_id     = cpl_id;
        h.status     = status;
        h.byte_count = byte_count;
        h.req_id     = req_id;
        h.tag        = tag;
        h.lower_addr = lower_addr;
        return h;
    endfunction

endpackage

// File: rtl/fejkon_pcie_cpl_gen_if.sv
// Request, BAR0 Avalon-MM and tx_st signals of the completion generator.
// The slave modport is the generator side; master is its environment.
interface fejkon_pcie_cpl_gen_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [15:0] req_reqid;
    logic [7:0]  req_tag;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [3:0]  req_first_be;

    logic [31:0] bar0_mm_address;
    logic        bar0_mm_read;
    logic [31:0] bar0_mm_readdata;
    logic        bar0_mm_readdatavalid;
    logic        bar0_mm_waitrequest;

    logic [255:0] tx_st_data;
    logic         tx_st_valid;
    logic         tx_st_ready;
    logic         tx_st_startofpacket;
    logic         tx_st_endofpacket;
    logic [1:0]   tx_st_empty;
    logic         tx_st_error;

    modport slave (
        input  req_valid, req_addr, req_reqid, req_tag,
        input  req_tc, req_attr, req_first_be,
        output req_ready,
        output bar0_mm_address, bar0_mm_read,
        input  bar0_mm_readdata, bar0_mm_readdatavalid,
        input  bar0_mm_waitrequest,
        output tx_st_data, tx_st_valid,
        output tx_st_startofpacket, tx_st_endofpacket,
        output tx_st_empty, tx_st_error,
        input  tx_st_ready
    );

    modport master (
        output req_valid, req_addr, req_reqid, req_tag,
        output req_tc, req_attr, req_first_be,
        input  req_ready,
        input  bar0_mm_address, bar0_mm_read,
        output bar0_mm_readdata, bar0_mm_readdatavalid,
        output bar0_mm_waitrequest,
        input  tx_st_data, tx_st_valid,
        input  tx_st_startofpacket, tx_st_endofpacket,
        input  tx_st_empty, tx_st_error,
        output tx_st_ready
    );

endinterface

// File: rtl/fejkon_pcie_cpl_be_decode.sv
// First-DW byte-enable decode for single-dword read completions.
// Yields completion byte count and the low two lower-address bits.
module fejkon_pcie_cpl_be_decode
    import fejkon_pcie_pkg::*;
(
    input  logic [3:0]  first_be,
    output logic [11:0] byte_count,
    output logic [1:0]  lower_addr
);

    always_comb begin
        byte_count = 12'd1;
        unique case (1'b1)
            first_be[3] & first_be[0]:
                byte_count = 12'd4;
            (~first_be[3] & first_be[2] & first_be[0]) |
            (first_be[3] & first_be[1] & ~first_be[0]):
                byte_count = 12'd3;
            (first_be == 4'b0011) |
            (first_be == 4'b0110) |
            (first_be == 4'b1100):
                byte_count = 12'd2;
            default:
                byte_count = 12'd1;
        endcase
    end

    always_comb begin
        lower_addr = 2'd0;
        if (first_be[0])
            lower_addr = 2'd0;
        else if (first_be[1])
            lower_addr = 2'd1;
        else if (first_be[2])
            lower_addr = 2'd2;
        else if (first_be[3])
            lower_addr = 2'd3;
    end

endmodule

// File: rtl/fejkon_pcie_cpl_gen.sv
// BAR0 single-DW read completer: MRd request -> Avalon read -> CplD beat.
// FEJKON_CPL_TIMEOUT_EN adds a read timeout that answers with a CA Cpl.
module fejkon_pcie_cpl_gen
    import fejkon_pcie_pkg::*;
#(
    parameter logic [15:0] COMPLETER_ID   = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fejkon_pcie_cpl_gen_if.slave  bus,
    output logic [15:0]           cpl_count
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    cpl_state_e   state;
    logic [31:0]  addr_q;
    logic [15:0]  reqid_q;
    logic [7:0]   tag_q;
    logic [2:0]   tc_q;
    logic [1:0]   attr_q;
    logic [3:0]   be_q;
    logic         rd_q;
    logic         req_ready_q;
    logic         tx_valid_q;
    logic [255:0] tx_data_q;
    logic [1:0]   tx_empty_q;

    logic [11:0]  byte_count;
    logic [1:0]   lower_idx;
    logic [6:0]   lower_addr;
    cpl_hdr_t     hdr_cpld;
    logic [255:0] beat_cpld;
    logic [1:0]   empty_cpld;
    logic         cmd_done;
    logic         data_now;

    fejkon_pcie_cpl_be_decode u_be_decode (
        .first_be   (be_q),
        .byte_count (byte_count),
        .lower_addr (lower_idx)
    );

    assign lower_addr = {addr_q[6:2], lower_idx};
    assign cmd_done   = (state == RD_CMD) && !bus.bar0_mm_waitrequest;
    assign data_now   = (cmd_done || state == RD_WAIT) &&
                        bus.bar0_mm_readdatavalid;

    assign hdr_cpld = cpl_hdr(FMT_CPLD, CPL_SC, 10'd1, COMPLETER_ID,
                              reqid_q, tag_q, tc_q, attr_q,
                              byte_count, lower_addr);

    // QW-aligned data lands in DW4 behind a pad DW; otherwise it follows DW2.
    always_comb begin
        beat_cpld       = '0;
        beat_cpld[95:0] = hdr_cpld;
        if (addr_q[2])
            beat_cpld[127:96] = bus.bar0_mm_readdata;
        else
            beat_cpld[159:128] = bus.bar0_mm_readdata;
    end

    assign empty_cpld = addr_q[2] ? 2'd2 : 2'd1;

`ifdef FEJKON_CPL_TIMEOUT_EN
    cpl_hdr_t    hdr_ca;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    assign hdr_ca  = cpl_hdr(FMT_CPL, CPL_CA, 10'd0, COMPLETER_ID,
                             reqid_q, tag_q, tc_q, attr_q,
                             byte_count, lower_addr);
    assign tmo_hit = tmo_cnt == 16'(TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            reqid_q     <= '0;
            tag_q       <= '0;
            tc_q        <= '0;
            attr_q      <= '0;
            be_q        <= '0;
            rd_q        <= 1'b0;
            req_ready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_empty_q  <= '0;
            cpl_count   <= '0;
`ifdef FEJKON_CPL_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        addr_q      <= bus.req_addr & 32'hFFFF_FFFC;
                        reqid_q     <= bus.req_reqid;
                        tag_q       <= bus.req_tag;
                        tc_q        <= bus.req_tc;
                        attr_q      <= bus.req_attr;
                        be_q        <= bus.req_first_be;
                        req_ready_q <= 1'b0;
                        rd_q        <= 1'b1;
                        state       <= RD_CMD;
`ifdef FEJKON_CPL_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                RD_CMD, RD_WAIT: begin
`ifdef FEJKON_CPL_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    if (cmd_done)
                        rd_q <= 1'b0;
                    if (data_now) begin
                        tx_data_q  <= beat_cpld;
                        tx_empty_q <= empty_cpld;
                        tx_valid_q <= 1'b1;
                        state      <= TX;
                    end
`ifdef FEJKON_CPL_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rd_q       <= 1'b0;
                        tx_data_q  <= {160'd0, hdr_ca};
                        tx_empty_q <= 2'd2;
                        tx_valid_q <= 1'b1;
                        state      <= TX;
                    end
`endif
                    else if (cmd_done)
                        state <= RD_WAIT;
                end
                TX: begin
                    if (bus.tx_st_ready) begin
                        tx_valid_q  <= 1'b0;
                        cpl_count   <= cpl_count + 16'd1;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready           = req_ready_q;
    assign bus.bar0_mm_address     = addr_q;
    assign bus.bar0_mm_read        = rd_q;
    assign bus.tx_st_data          = tx_data_q;
    assign bus.tx_st_valid         = tx_valid_q;
    assign bus.tx_st_startofpacket = tx_valid_q;
    assign bus.tx_st_endofpacket   = tx_valid_q;
    assign bus.tx_st_empty         = tx_empty_q;
    assign bus.tx_st_error         = 1'b0;

endmodule

// File: tb/tb_fejkon_pcie_cpl_gen.sv
// Testbench for fejkon_pcie_cpl_gen: directed and random reads vs a model.
// Define FEJKON_CPL_TIMEOUT_EN to also exercise the read timeout.
module tb_fejkon_pcie_cpl_gen;

    localparam logic [15:0] CID = 16'hBEEF;
    localparam int          TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpl_count;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [15:0]  exp_count = '0;
    logic [255:0] last_beat;

    fejkon_pcie_cpl_gen_if bus();

    fejkon_pcie_cpl_gen #(
        .COMPLETER_ID   (CID),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .cpl_count (cpl_count)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference completion built from the PCIe rules with plain arithmetic.
    task automatic model(input logic [31:0] a, input logic [3:0] be,
                         input logic [15:0] rid, input logic [7:0] tg,
                         input logic [2:0] tc, input logic [1:0] at,
                         input logic [31:0] rd,
                         output logic [255:0] beat, output logic [1:0] empty);
        int lo = -1;
        int hi = 0;
        int bc;
        logic [6:0] la;
        logic [31:0] dw [8];
        for (int i = 0; i < 4; i++)
            if (be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        bc = (lo < 0) ? 1 : hi - lo + 1;
        if (lo < 0) lo = 0;
        la = 7'((a & 32'h7C) + 32'(lo));
        for (int i = 0; i < 8; i++) dw[i] = '0;
        dw[0] = 32'h4A00_0001 | (32'(tc) << 20) | (32'(at) << 12);
        dw[1] = (32'(CID) << 16) | 32'(bc);
        dw[2] = (32'(rid) << 16) | (32'(tg) << 8) | 32'(la);
        if (la[2]) begin
            dw[3] = rd;
            empty = 2'd2;
        end else begin
            dw[4] = rd;
            empty = 2'd1;
        end
        for (int i = 0; i < 8; i++) beat[i*32 +: 32] = dw[i];
    endtask

    task automatic send_req(input logic [31:0] a, input logic [3:0] be,
                            input logic [15:0] rid, input logic [7:0] tg,
                            input logic [2:0] tc, input logic [1:0] at);
        for (int c = 0; c < 20 && !bus.req_ready; c++) tick();
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_first_be = be;
        bus.req_reqid    = rid;
        bus.req_tag      = tg;
        bus.req_tc       = tc;
        bus.req_attr     = at;
        tick();
        bus.req_valid    = 1'b0;
        bus.req_addr     = $urandom;
        bus.req_tag      = 8'($urandom);
        check("req_ready_busy", bus.req_ready, 0);
    endtask

    // w: waitrequest cycles, d: cycles from read accept to readdatavalid,
    // s: tx_st_ready stall cycles
    task automatic run_req(input logic [31:0] a, input logic [3:0] be,
                           input logic [15:0] rid, input logic [7:0] tg,
                           input logic [2:0] tc, input logic [1:0] at,
                           input logic [31:0] rd,
                           input int w, input int d, input int s);
        logic [255:0] exp_beat;
        logic [1:0]   exp_empty;
        int rd_cyc = 0;
        int wcnt = 0;
        int acc_c = 0;
        bit acc = 0;
        bit sent = 0;
        model(a, be, rid, tg, tc, at, rd, exp_beat, exp_empty);
        send_req(a, be, rid, tg, tc, at);
        check("rd_start", bus.bar0_mm_read, 1);
        for (int c = 0; c < 200 && !sent; c++) begin
            bus.bar0_mm_readdatavalid = 1'b0;
            bus.bar0_mm_waitrequest   = (wcnt < w);
            if (bus.bar0_mm_read) begin
                rd_cyc++;
                wcnt++;
                check("mm_addr", bus.bar0_mm_address, a & 32'hFFFF_FFFC);
                if (!bus.bar0_mm_waitrequest && !acc) begin
                    acc   = 1;
                    acc_c = c;
                end
            end
            if (acc && c == acc_c + d) begin
                bus.bar0_mm_readdatavalid = 1'b1;
                bus.bar0_mm_readdata      = rd;
                sent = 1;
            end
            tick();
        end
        bus.bar0_mm_readdatavalid = 1'b0;
        bus.bar0_mm_waitrequest   = 1'b0;
        bus.bar0_mm_readdata      = $urandom;
        check("rdv_sent", sent, 1);
        check("rd_cycles", rd_cyc, w + 1);
        check("rd_low", bus.bar0_mm_read, 0);
        check("tx_valid", bus.tx_st_valid, 1);
        check("tx_data", bus.tx_st_data, exp_beat);
        check("tx_empty", bus.tx_st_empty, exp_empty);
        check("tx_sop_eop", {bus.tx_st_startofpacket, bus.tx_st_endofpacket}, 2'b11);
        check("tx_error", bus.tx_st_error, 0);
        last_beat = bus.tx_st_data;
        for (int i = 0; i < s; i++) begin
            bus.tx_st_ready = 1'b0;
            bus.req_valid   = 1'b1;
            tick();
            check("stall_valid", bus.tx_st_valid, 1);
            check("stall_data", bus.tx_st_data, exp_beat);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_count", cpl_count, exp_count);
        end
        bus.req_valid   = 1'b0;
        bus.tx_st_ready = 1'b1;
        tick();
        bus.tx_st_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check("tx_done_valid", bus.tx_st_valid, 0);
        check("cpl_count", cpl_count, exp_count);
        check("req_ready_back", bus.req_ready, 1);
    endtask

    initial begin
        bus.req_valid             = 1'b0;
        bus.req_addr              = '0;
        bus.req_reqid             = '0;
        bus.req_tag               = '0;
        bus.req_tc                = '0;
        bus.req_attr              = '0;
        bus.req_first_be          = '0;
        bus.bar0_mm_readdata      = '0;
        bus.bar0_mm_readdatavalid = 1'b0;
        bus.bar0_mm_waitrequest   = 1'b0;
        bus.tx_st_ready           = 1'b0;

        repeat (3) tick();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_read", bus.bar0_mm_read, 0);
        check("rst_addr", bus.bar0_mm_address, 0);
        check("rst_valid", bus.tx_st_valid, 0);
        check("rst_data", bus.tx_st_data, 0);
        check("rst_frame", {bus.tx_st_startofpacket, bus.tx_st_endofpacket,
                            bus.tx_st_empty, bus.tx_st_error}, 0);
        check("rst_count", cpl_count, 0);
        reset_n = 1'b1;
        tick();
        check("rel_req_ready", bus.req_ready, 1);

        run_req(32'h10, 4'b1111, 16'h0100, 8'h05, 3'd0, 2'd0,
                32'hCAFE_F00D, 0, 0, 0);
        check("t1_dw0", last_beat[31:0], 32'h4A00_0001);
        check("t1_bc", last_beat[43:32], 12'd4);
        check("t1_la", last_beat[70:64], 7'h10);
        check("t1_dw3", last_beat[127:96], 32'h0);
        check("t1_dw4", last_beat[159:128], 32'hCAFE_F00D);
        check("t1_count", cpl_count, 16'd1);

        run_req(32'h14, 4'b0110, 16'h0100, 8'h06, 3'd0, 2'd0,
                32'h1234_5678, 0, 1, 0);
        check("t2_bc", last_beat[43:32], 12'd2);
        check("t2_la", last_beat[70:64], 7'h15);
        check("t2_dw3", last_beat[127:96], 32'h1234_5678);
        check("t2_dw4", last_beat[159:128], 32'h0);

        run_req(32'h40, 4'b1111, 16'hA5A5, 8'h77, 3'd5, 2'd2,
                32'hDEAD_BEEF, 5, 3, 4);

        // Reset while waiting for read data, then a stale readdatavalid.
        send_req(32'h80, 4'b1111, 16'h1111, 8'h22, 3'd1, 2'd1);
        bus.bar0_mm_waitrequest = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", bus.tx_st_valid, 0);
        check("ar_read", bus.bar0_mm_read, 0);
        check("ar_addr", bus.bar0_mm_address, 0);
        check("ar_count", cpl_count, 0);
        check("ar_req_ready", bus.req_ready, 0);
        exp_count = '0;
        tick();
        reset_n = 1'b1;
        bus.bar0_mm_readdatavalid = 1'b1;
        bus.bar0_mm_readdata      = 32'h5555_AAAA;
        tick();
        bus.bar0_mm_readdatavalid = 1'b0;
        check("ar_req_ready_rel", bus.req_ready, 1);
        check("ar_no_read", bus.bar0_mm_read, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_beat", bus.tx_st_valid, 0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0] be;
            be = (i % 10 == 0) ? 4'b0000 : 4'($urandom);
            run_req($urandom, be, 16'($urandom), 8'($urandom),
                    3'($urandom), 2'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2));
        end

`ifdef FEJKON_CPL_TIMEOUT_EN
        send_req(32'h20, 4'b1111, 16'h0200, 8'h09, 3'd0, 2'd0);
        bus.bar0_mm_waitrequest = 1'b0;
        for (int c = 0; c < 40 && !bus.tx_st_valid; c++) tick();
        check("tmo_valid", bus.tx_st_valid, 1);
        check("tmo_read", bus.bar0_mm_read, 0);
        check("tmo_dw0", bus.tx_st_data[31:0], 32'h0A00_0000);
        check("tmo_status", bus.tx_st_data[47:45], 3'b100);
        check("tmo_empty", bus.tx_st_empty, 2'd2);
        check("tmo_nodata", bus.tx_st_data[255:96], 0);
        bus.bar0_mm_readdatavalid = 1'b1;
        bus.tx_st_ready           = 1'b1;
        tick();
        bus.tx_st_ready = 1'b0;
        tick();
        bus.bar0_mm_readdatavalid = 1'b0;
        exp_count = exp_count + 16'd1;
        tick();
        check("tmo_late_drop", bus.tx_st_valid, 0);
        check("tmo_count", cpl_count, exp_count);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
